delay_ctrl: RTL and testbench

Sequencing controller for the shared sample delay line. It takes new delay settings through a valid/ready request port and drives the delay line's `delay` input, either as a single jump or as a one-step-per-sample slew. It produces `out_valid`, which qualifies the delay line output and masks the start-up and retune glitch the delay line itself does not hide. It sits beside the delay line on the same `clk` and `ce_in` strobe.

---
 rtl/delay_ctrl.sv | 112 +++++++++++
 tb/tb_delay_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/delay_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | delay_ctrl: sequences delay-line retunes (jump/slew) and masks fill glitch |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module delay_ctrl #(
  parameter int AW         = 8,
  parameter int INIT_DELAY = 0,
  parameter int FILL_PAD   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce_in,
  input  logic          req_valid,
  input  logic [AW-1:0] req_delay,
  input  logic          req_slew,
  output logic          req_ready,
  output logic [AW-1:0] delay,
  output logic          out_valid,
  output logic          slewing,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_SLEW = 2'd2
  } state_t;

  localparam logic [AW-1:0] c_init_delay = AW'(INIT_DELAY);
  localparam logic [AW:0]   c_pad        = (AW+1)'(FILL_PAD);
  localparam logic [AW:0]   c_cnt_init   = {1'b0, c_init_delay} + c_pad;
  localparam logic [AW:0]   c_cnt_one    = (AW+1)'(1);

  state_t        state_q;
  logic [AW-1:0] delay_q;
  logic [AW-1:0] target_q;
  logic [AW:0]   cnt_q;
  logic          out_valid_q;
  logic          slewing_q;
  logic [AW-1:0] delay_step_d;

  // One unsigned step toward target; holds when already there, so never overshoots.
  always_comb begin
    delay_step_d = delay_q;
    if (target_q > delay_q) begin
      delay_step_d = delay_q + 1'b1;
    end else if (target_q < delay_q) begin
      delay_step_d = delay_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      delay_q     <= c_init_delay;
      target_q    <= c_init_delay;
      cnt_q       <= c_cnt_init;
      out_valid_q <= 1'b0;
      slewing_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (ce_in) begin
            // Saturating compare also covers a zero-length fill (FILL_PAD=0, delay 0).
            if (cnt_q <= c_cnt_one) begin
              cnt_q       <= '0;
              state_q     <= S_RUN;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - c_cnt_one;
            end
          end
        end
        S_RUN: begin
          if (req_valid && (req_delay != delay_q)) begin
            if (req_slew) begin
              target_q  <= req_delay;
              slewing_q <= 1'b1;
              state_q   <= S_SLEW;
            end else begin
              delay_q     <= req_delay;
              cnt_q       <= {1'b0, req_delay} + c_pad;
              out_valid_q <= 1'b0;
              state_q     <= S_FILL;
            end
          end
        end
        S_SLEW: begin
          if (ce_in) begin
            delay_q <= delay_step_d;
            if (delay_step_d == target_q) begin
              slewing_q <= 1'b0;
              state_q   <= S_RUN;
            end
          end
        end
        default: begin
          state_q <= S_FILL;
        end
      endcase
    end
  end

  assign req_ready = (state_q == S_RUN);
  assign busy      = (state_q != S_RUN);
  assign delay     = delay_q;
  assign out_valid = out_valid_q;
  assign slewing   = slewing_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_delay_ctrl: vector table + scoreboard bench for delay_ctrl              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_delay_ctrl;

  localparam int AW = 8;

  logic          clk;
  logic          rst_n;
  logic          ce_in;
  logic          req_valid;
  logic [AW-1:0] req_delay;
  logic          req_slew;
  logic          req_ready;
  logic [AW-1:0] delay;
  logic          out_valid;
  logic          slewing;
  logic          busy;

  delay_ctrl #(.AW(AW), .INIT_DELAY(0), .FILL_PAD(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce_in     (ce_in),
    .req_valid (req_valid),
    .req_delay (req_delay),
    .req_slew  (req_slew),
    .req_ready (req_ready),
    .delay     (delay),
    .out_valid (out_valid),
    .slewing   (slewing),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rstn;
    logic          ce;
    logic          rv;
    logic [AW-1:0] rd;
    logic          rs;
    logic [AW-1:0] e_d;
    logic          e_ov;
    logic          e_sl;
    logic          e_rdy;
  } vec_t;

  typedef struct {
    string         name;
    logic [AW-1:0] d;
    logic          ov;
    logic          sl;
    logic          rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Drive one cycle of inputs, queue the expected post-edge outputs, then score them.
  task automatic step(input string name, input logic rstn, input logic ce, input logic rv,
                      input logic [AW-1:0] rd, input logic rs, input logic [AW-1:0] e_d,
                      input logic e_ov, input logic e_sl, input logic e_rdy);
    exp_t e;
    logic [AW+3:0] act;
    logic [AW+3:0] req;
    rst_n     = rstn;
    ce_in     = ce;
    req_valid = rv;
    req_delay = rd;
    req_slew  = rs;
    e.name = name; e.d = e_d; e.ov = e_ov; e.sl = e_sl; e.rdy = e_rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    act = {delay, out_valid, slewing, req_ready, busy};
    req = {e.d, e.ov, e.sl, e.rdy, ~e.rdy};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @%0t: got delay=%0d ov=%b sl=%b rdy=%b busy=%b, want delay=%0d ov=%b sl=%b rdy=%b busy=%b",
               e.name, $time, delay, out_valid, slewing, req_ready, busy,
               e.d, e.ov, e.sl, e.rdy, ~e.rdy);
    end
  endtask

  vec_t vecs[12];

  initial begin
    rst_n = 1'b0; ce_in = 1'b0; req_valid = 1'b0; req_delay = '0; req_slew = 1'b0;
    @(posedge clk);
    #1;

    //          rstn ce  rv  rd  rs   e_d ov  sl  rdy
    vecs[0]  = '{1'b0,1'b1,1'b0,8'd0,1'b0, 8'd0,1'b0,1'b0,1'b0}; // reset
    vecs[1]  = '{1'b1,1'b1,1'b0,8'd0,1'b0, 8'd0,1'b0,1'b0,1'b0}; // strobe 1
    vecs[2]  = '{1'b1,1'b1,1'b0,8'd0,1'b0, 8'd0,1'b1,1'b0,1'b1}; // strobe 2 -> RUN
    vecs[3]  = '{1'b1,1'b1,1'b0,8'd0,1'b0, 8'd0,1'b1,1'b0,1'b1};
    vecs[4]  = '{1'b1,1'b0,1'b1,8'd0,1'b0, 8'd0,1'b1,1'b0,1'b1}; // equal jump no-op
    vecs[5]  = '{1'b1,1'b1,1'b1,8'd0,1'b1, 8'd0,1'b1,1'b0,1'b1}; // equal slew no-op
    vecs[6]  = '{1'b1,1'b1,1'b1,8'd3,1'b1, 8'd0,1'b1,1'b1,1'b0}; // slew accept, ce not a step
    vecs[7]  = '{1'b1,1'b0,1'b0,8'd0,1'b0, 8'd0,1'b1,1'b1,1'b0};
    vecs[8]  = '{1'b1,1'b1,1'b0,8'd0,1'b0, 8'd1,1'b1,1'b1,1'b0};
    vecs[9]  = '{1'b1,1'b1,1'b1,8'd9,1'b0, 8'd2,1'b1,1'b1,1'b0}; // held off in SLEW
    vecs[10] = '{1'b1,1'b1,1'b1,8'd9,1'b0, 8'd3,1'b1,1'b0,1'b1}; // final step -> RUN
    vecs[11] = '{1'b1,1'b0,1'b0,8'd0,1'b0, 8'd3,1'b1,1'b0,1'b1};

    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rstn, vecs[i].ce, vecs[i].rv, vecs[i].rd,
           vecs[i].rs, vecs[i].e_d, vecs[i].e_ov, vecs[i].e_sl, vecs[i].e_rdy);
    end

    // Jump 3 -> 10, ce every 3rd cycle: valid on the 12th strobe.
    step("jump10_acc", 1'b1, 1'b0, 1'b1, 8'd10, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step("jump10_gap", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0);
      step("jump10_gap", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0);
      step($sformatf("jump10_strobe%0d", k), 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd10,
           (k == 12), 1'b0, (k == 12));
    end

    // Slew 10 -> 7.
    step("slew7_acc", 1'b1, 1'b0, 1'b1, 8'd7, 1'b1, 8'd10, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step($sformatf("slew7_step%0d", k), 1'b1, 1'b1, 1'b0, 8'd0, 1'b0,
           8'(10 - k), 1'b1, (k < 3), (k == 3));
    end
    step("slew7_idle", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd7, 1'b1, 1'b0, 1'b1);

    // Jump to 255 with a second request held high through the whole fill.
    step("jump255_acc", 1'b1, 1'b1, 1'b1, 8'd255, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 257; k++) begin
      step($sformatf("jump255_strobe%0d", k), 1'b1, 1'b1, 1'b1, 8'd5, 1'b0, 8'd255,
           (k == 257), 1'b0, (k == 257));
    end
    step("held_req_acc", 1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step($sformatf("fill5_strobe%0d", k), 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd5,
           (k == 7), 1'b0, (k == 7));
    end

    // Reset mid-slew toward 20; target must be forgotten.
    step("slew20_acc", 1'b1, 1'b0, 1'b1, 8'd20, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0);
    step("slew20_s1", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd6, 1'b1, 1'b1, 1'b0);
    step("slew20_s2", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd7, 1'b1, 1'b1, 1'b0);
    step("midslew_rst", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step("post_rst_s1", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step("post_rst_s2", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step("post_rst_idle", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
